// File: rtl/line_serializer.sv
`default_nettype none
// ============================================================================
// Module      : line_serializer
// Description : Captures one selected display line (N_CHARS characters of
//               CHAR_W bits) on a load strobe and emits it one character per
//               valid/ready handshake, leftmost character first, followed by
//               a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module line_serializer #(
  parameter int CHAR_W  = 7,
  parameter int N_CHARS = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHAR_W*N_CHARS-1:0]   line_in,
  input  logic                        load,
  output logic                        busy,
  output logic [CHAR_W-1:0]           char_out,
  output logic                        char_valid,
  input  logic                        char_ready,
  output logic                        char_last,
  output logic                        done
);

  localparam int LINE_W = CHAR_W * N_CHARS;
  // Index of the final character; the 4-bit index never counts past it.
  localparam logic [3:0] C_LAST_IDX = 4'(N_CHARS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [LINE_W-1:0]   shreg_q, shreg_d;

  // State, character index and line shift register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic: capture on load when not sending, advance on handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load) begin
          shreg_d = line_in;
          idx_d   = 4'd0;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        // Load is ignored here; only the sink handshake moves the line along.
        if (char_ready) begin
          if (idx_q == C_LAST_IDX) begin
            // Register is left as-is; its contents are stale outside SEND.
            state_d = S_DONE;
          end else begin
            shreg_d = {shreg_q[LINE_W-CHAR_W-1:0], {CHAR_W{1'b0}}};
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output.
  always_comb begin
    busy       = (state_q == S_SEND);
    char_valid = (state_q == S_SEND);
    char_last  = (state_q == S_SEND) && (idx_q == C_LAST_IDX);
    done       = (state_q == S_DONE);
    char_out   = shreg_q[LINE_W-1 -: CHAR_W];
  end

endmodule
`default_nettype wire

// File: tb/tb_line_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_serializer
// Description : Directed self-checking bench for line_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_serializer;

  localparam int CHAR_W  = 7;
  localparam int N_CHARS = 11;
  localparam int LINE_W  = CHAR_W * N_CHARS;

  logic              clk = 1'b0;
  logic              rst;
  logic [LINE_W-1:0] line_in;
  logic              load;
  logic              busy;
  logic [CHAR_W-1:0] char_out;
  logic              char_valid;
  logic              char_ready;
  logic              char_last;
  logic              done;

  int n_pass  = 0;
  int n_total = 0;

  logic [CHAR_W-1:0] exp_c   [N_CHARS];
  logic [CHAR_W-1:0] total_c [N_CHARS] = '{7'h54, 7'h4F, 7'h54, 7'h41, 7'h4C, 7'h20,
                                           7'h31, 7'h32, 7'h2E, 7'h35, 7'h30};
  logic [CHAR_W-1:0] item_c  [N_CHARS] = '{7'h49, 7'h54, 7'h45, 7'h4D, 7'h20, 7'h43,
                                           7'h4F, 7'h55, 7'h4E, 7'h54, 7'h20};
  logic [LINE_W-1:0] total_line;
  logic [LINE_W-1:0] item_line;

  line_serializer #(
    .CHAR_W  (CHAR_W),
    .N_CHARS (N_CHARS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .line_in    (line_in),
    .load       (load),
    .busy       (busy),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_last  (char_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_valid"}, 32'(char_valid), 32'd0);
    chk({tag, "_last"},  32'(char_last),  32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
  endtask

  // Walk the line in exp_c from character 0, with optional random stalls and
  // an optional load pulse (of other_line) during character inject_at.
  // Returns positioned just after the final handshake edge.
  task automatic send_line(input string tag, input int stall_max, input int inject_at,
                           input logic [LINE_W-1:0] other_line);
    for (int i = 0; i < N_CHARS; i++) begin
      int k;
      k = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
      for (int s = 0; s < k; s++) begin
        char_ready = 1'b0;
        chk($sformatf("%s_stall%0d_char", tag, i),  32'(char_out),   32'(exp_c[i]));
        chk($sformatf("%s_stall%0d_valid", tag, i), 32'(char_valid), 32'd1);
        step();
      end
      if (i == inject_at) begin
        load    = 1'b1;
        line_in = other_line;
      end
      char_ready = 1'b1;
      chk($sformatf("%s_c%0d_char", tag, i),  32'(char_out),   32'(exp_c[i]));
      chk($sformatf("%s_c%0d_valid", tag, i), 32'(char_valid), 32'd1);
      chk($sformatf("%s_c%0d_busy", tag, i),  32'(busy),       32'd1);
      chk($sformatf("%s_c%0d_last", tag, i),  32'(char_last),  (i == N_CHARS - 1) ? 32'd1 : 32'd0);
      chk($sformatf("%s_c%0d_done", tag, i),  32'(done),       32'd0);
      step();
      load = 1'b0;
    end
  endtask

  // Main directed sequence.
  initial begin
    for (int i = 0; i < N_CHARS; i++) begin
      total_line[LINE_W-1-CHAR_W*i -: CHAR_W] = total_c[i];
      item_line [LINE_W-1-CHAR_W*i -: CHAR_W] = item_c[i];
    end
    rst        = 1'b1;
    load       = 1'b1;
    line_in    = total_line;
    char_ready = 1'b1;

    // Reset held two cycles with load high.
    step();
    step();
    chk_idle_outputs("rst");
    chk("rst_char", 32'(char_out), 32'd0);
    rst  = 1'b0;
    load = 1'b0;
    step();
    chk_idle_outputs("post_rst");

    // Full line without stalls.
    line_in = total_line;
    load    = 1'b1;
    step();
    load = 1'b0;
    exp_c = total_c;
    send_line("full", 0, -1, '0);
    chk("full_done",  32'(done),       32'd1);
    chk("full_busy",  32'(busy),       32'd0);
    chk("full_valid", 32'(char_valid), 32'd0);
    step();
    chk_idle_outputs("full_end");

    // Same line under pseudo-random back-pressure.
    line_in = total_line;
    load    = 1'b1;
    step();
    load = 1'b0;
    send_line("bp", 3, -1, '0);
    chk("bp_done", 32'(done), 32'd1);
    step();
    chk_idle_outputs("bp_end");

    // Load while busy at character 4 must be ignored.
    line_in = total_line;
    load    = 1'b1;
    step();
    load = 1'b0;
    send_line("lwb", 0, 4, item_line);
    chk("lwb_done", 32'(done), 32'd1);

    // Back-to-back: reload during the DONE cycle.
    line_in = item_line;
    load    = 1'b1;
    step();
    load = 1'b0;
    chk("b2b_valid", 32'(char_valid), 32'd1);
    chk("b2b_char0", 32'(char_out),   32'h49);
    chk("b2b_done",  32'(done),       32'd0);
    exp_c = item_c;
    send_line("b2b", 0, -1, '0);
    chk("b2b_done2", 32'(done), 32'd1);
    step();
    chk_idle_outputs("b2b_end");

    // Reset mid-line at character 6.
    line_in = total_line;
    load    = 1'b1;
    step();
    load       = 1'b0;
    char_ready = 1'b1;
    exp_c      = total_c;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("mid_c%0d_char", i), 32'(char_out), 32'(exp_c[i]));
      step();
    end
    chk("mid_c6_char", 32'(char_out), 32'(exp_c[6]));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_outputs("mid_rst");
    chk("mid_rst_char", 32'(char_out), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("mid_after%0d_valid", i), 32'(char_valid), 32'd0);
      chk($sformatf("mid_after%0d_done", i),  32'(done),       32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
